fetch_sequencer: RTL and testbench

Control FSM that owns the program counter and sequences instruction fetch for the pipelined core. Drives the PC into the instruction ROM and fetch stage. Arbitrates between start, halt, hazard stall and resolved-branch redirect. Generates the pipeline flush pulse after a taken branch and holds the core in a halted state after a halt instruction.

---
 rtl/fetch_sequencer_if.sv | 57 +++++
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer control/status bundle.
// Optional perf counters appear when FETCH_PERF_EN is defined.
interface fetch_sequencer_if #(
  parameter int PC_W = 16
);
  logic            go;
  logic            halt_req;
  logic            stall_req;
  logic            br_valid;
  logic            br_taken;
  logic            br_dir;
  logic [PC_W-1:0] br_base;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            halted;
  logic            busy;
`ifdef FETCH_PERF_EN
  logic [15:0]     fetch_count;
  logic [15:0]     taken_count;

  modport master (
    output go, halt_req, stall_req,
    output br_valid, br_taken, br_dir,
    output br_base, br_offset,
    input  pc, pc_valid, flush,
    input  halted, busy,
    input  fetch_count, taken_count
  );

  modport slave (
    input  go, halt_req, stall_req,
    input  br_valid, br_taken, br_dir,
    input  br_base, br_offset,
    output pc, pc_valid, flush,
    output halted, busy,
    output fetch_count, taken_count
  );
`else
  modport master (
    output go, halt_req, stall_req,
    output br_valid, br_taken, br_dir,
    output br_base, br_offset,
    input  pc, pc_valid, flush,
    input  halted, busy
  );

  modport slave (
    input  go, halt_req, stall_req,
    input  br_valid, br_taken, br_dir,
    input  br_base, br_offset,
    output pc, pc_valid, flush,
    output halted, busy
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer: start, halt, stall, redirect+flush.
// Define FETCH_PERF_EN to add saturating fetch/taken counters.
module fetch_sequencer #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    HALT
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            busy_q, busy_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] target;
  logic            start;
  logic            redirect;

  assign target = bus.br_dir ? bus.br_base + bus.br_offset
                             : bus.br_base - bus.br_offset;

  // Next-state and registered-output logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = 1'b0;
    flush_d    = 1'b0;
    halted_d   = 1'b0;
    cnt_d      = cnt_q;
    start      = 1'b0;
    redirect   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d    = RUN;
          pc_d       = RESET_PC;
          pc_valid_d = 1'b1;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (bus.br_valid && bus.br_taken) begin
          state_d  = FLUSH;
          pc_d     = target;
          flush_d  = 1'b1;
          cnt_d    = CNT_INIT;
          redirect = 1'b1;
        end else if (!bus.stall_req) begin
          pc_d       = pc_q + 1'b1;
          pc_valid_d = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      HALT: begin
        halted_d = 1'b1;
        if (bus.go) begin
          state_d    = RUN;
          pc_d       = RESET_PC;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
          start      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == FLUSH);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.halted   = halted_q;
  assign bus.busy     = busy_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] tcnt_q, tcnt_d;

  // Saturating perf counters; an accepted go restarts them.
  always_comb begin
    fcnt_d = fcnt_q;
    tcnt_d = tcnt_q;
    if (start) begin
      fcnt_d = '0;
      tcnt_d = '0;
    end else begin
      if (pc_valid_q && fcnt_q != 16'hFFFF)
        fcnt_d = fcnt_q + 16'd1;
      if (redirect && tcnt_q != 16'hFFFF)
        tcnt_d = tcnt_q + 16'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign bus.fetch_count = fcnt_q;
  assign bus.taken_count = tcnt_q;
`else
  logic unused_start;
  logic unused_redirect;
  assign unused_start    = start;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer.
// Perf counter checks run only when FETCH_PERF_EN is defined.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(16)) bus ();

  fetch_sequencer #(
    .PC_W(16),
    .RESET_PC(16'h0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        go, halt, stall;
    logic        bv, bt, bd;
    logic [15:0] base, off;
    logic [15:0] e_pc;
    logic        e_v, e_f, e_h, e_b;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    logic g, logic h, logic s,
    logic bv, logic bt, logic bd,
    logic [15:0] base, logic [15:0] off,
    logic [15:0] pc, logic v, logic f,
    logic hl, logic b);
    vec_t t;
    t.go = g; t.halt = h; t.stall = s;
    t.bv = bv; t.bt = bt; t.bd = bd;
    t.base = base; t.off = off;
    t.e_pc = pc; t.e_v = v; t.e_f = f;
    t.e_h = hl; t.e_b = b;
    return t;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic chk_out(string nm,
                         logic [15:0] pc, logic v,
                         logic f, logic h, logic b);
    chk({nm, ".pc"}, 32'(bus.pc), 32'(pc));
    chk({nm, ".v"}, 32'(bus.pc_valid), 32'(v));
    chk({nm, ".f"}, 32'(bus.flush), 32'(f));
    chk({nm, ".h"}, 32'(bus.halted), 32'(h));
    chk({nm, ".b"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic drive(vec_t t);
    bus.go        = t.go;
    bus.halt_req  = t.halt;
    bus.stall_req = t.stall;
    bus.br_valid  = t.bv;
    bus.br_taken  = t.bt;
    bus.br_dir    = t.bd;
    bus.br_base   = t.base;
    bus.br_offset = t.off;
  endtask

  task automatic idle_in();
    drive(mk(0,0,0,0,0,0,16'h0,16'h0,
             16'h0,0,0,0,0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // g h s bv bt bd base off | pc v f h b
    tbl.push_back(mk(0,1,1,1,1,1,16'h3,16'h3,
                     16'h0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,16'h0,16'h0,
                     16'h0000,1,0,0,1));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                       16'(i),1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1,1,16'h4,16'h10,
                     16'h0014,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0014,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0014,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0015,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1,0,16'h2,16'h5,
                     16'hFFFD,0,1,0,1));
    tbl.push_back(mk(1,1,0,1,1,1,16'h100,16'h1,
                     16'hFFFD,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,16'h0,16'h0,
                     16'hFFFD,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'hFFFE,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'hFFFF,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0000,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1,1,16'h0,16'h7,
                     16'h0007,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0007,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0007,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0008,1,0,0,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,1,0,0,0,16'h0,16'h0,
                       16'h0008,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,16'h0,16'h0,
                     16'h0009,1,0,0,1));
    tbl.push_back(mk(0,1,0,1,1,1,16'h40,16'h1,
                     16'h0009,0,0,1,0));
    tbl.push_back(mk(0,0,1,1,1,1,16'h40,16'h1,
                     16'h0009,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,16'h0,16'h0,
                     16'h0000,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,0,1,16'h80,16'h8,
                     16'h0001,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,16'h0,16'h0,
                     16'h0002,1,0,0,1));

    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("post_rst", 16'h0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_pc,
              tbl[i].e_v, tbl[i].e_f,
              tbl[i].e_h, tbl[i].e_b);
    end

    // Async reset in the middle of a flush.
    drive(mk(0,0,0,1,1,1,16'h10,16'h10,
             16'h0,0,0,0,0));
    step();
    chk_out("pre_rst_flush", 16'h0020, 0, 1, 0, 1);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 16'h0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    chk_out("idle_wait", 16'h0, 0, 0, 0, 0);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk_out("restart", 16'h0, 1, 0, 0, 1);

`ifdef FETCH_PERF_EN
    chk("fc_go", 32'(bus.fetch_count), 32'd0);
    repeat (9) step();
    chk_out("perf_seq", 16'h9, 1, 0, 0, 1);
    drive(mk(0,0,0,1,1,1,16'h100,16'h0,
             16'h0,0,0,0,0));
    step();
    idle_in();
    repeat (2) step();
    chk_out("perf_tgt", 16'h100, 1, 0, 0, 1);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    chk("fc_11", 32'(bus.fetch_count), 32'd11);
    chk("tc_1", 32'(bus.taken_count), 32'd1);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("fc_clr", 32'(bus.fetch_count), 32'd0);
    chk("tc_clr", 32'(bus.taken_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
